// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 encodings,
// FSM state type and default datapath width.
package muldiv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_sign.sv
// Combinational sign handling: operand magnitudes/signs on the way in,
// conditional two's-complement of the double-width result on the way out.
module muldiv_sign #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   op1,
    input  logic [XLEN-1:0]   op2,
    input  logic              s1,
    input  logic              s2,
    input  logic [2*XLEN-1:0] val,
    input  logic              neg_val,
    output logic [XLEN-1:0]   mag1,
    output logic [XLEN-1:0]   mag2,
    output logic              neg1,
    output logic              neg2,
    output logic [2*XLEN-1:0] val_out
);

    assign neg1    = s1 & op1[XLEN-1];
    assign neg2    = s2 & op2[XLEN-1];
    assign mag1    = neg1 ? -op1 : op1;
    assign mag2    = neg2 ? -op2 : op2;
    assign val_out = neg_val ? -val : val;

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide (RV32M-style funct3), XLEN iterations + 1
// finalize edge; divide-by-zero and signed overflow finish after a single edge.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      field,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            ready,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op;
    logic [XLEN-1:0] opd;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            neg1_r;
    logic            neg2_r;
    logic            byp;

    logic            s1, s2, is_div, div0, ovf;
    logic [XLEN-1:0] mag1, mag2, byp_val;
    logic            neg1, neg2;
    logic [XLEN:0]   mul_sum, div_t, div_d;
    logic            div_ok;
    logic [2*XLEN-1:0] fin_val, fin_out;
    logic            fin_neg;
    logic [XLEN-1:0] fin_res;

    assign ready = (state != S_CALC);

    always_comb begin
        is_div = field[2];
        s1     = (field == F_MUL) || (field == F_MULH) || (field == F_MULHSU) ||
                 (field == F_DIV) || (field == F_REM);
        s2     = (field == F_MUL) || (field == F_MULH) ||
                 (field == F_DIV) || (field == F_REM);
        div0   = is_div && (op2 == '0);
        ovf    = ((field == F_DIV) || (field == F_REM)) &&
                 (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
        // Remainder ops (field[1]) take the remainder side of the special-case table
        if (div0)
            byp_val = field[1] ? op1 : '1;
        else
            byp_val = field[1] ? '0 : op1;
    end

    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
        div_t   = {hi, lo[XLEN-1]};
        div_d   = div_t - {1'b0, opd};
        div_ok  = !div_d[XLEN];
    end

    // Quotient sign is the XOR of operand signs; remainder follows the dividend
    always_comb begin
        fin_val = {hi, lo};
        fin_neg = neg1_r ^ neg2_r;
        if (op[2]) begin
            fin_val = {{XLEN{1'b0}}, (op[1] ? hi : lo)};
            fin_neg = op[1] ? neg1_r : (neg1_r ^ neg2_r);
        end
        fin_res = (op == F_MUL || op[2]) ? fin_out[XLEN-1:0] : fin_out[2*XLEN-1:XLEN];
    end

    muldiv_sign #(.XLEN(XLEN)) u_sign (
        .op1     (op1),
        .op2     (op2),
        .s1      (s1),
        .s2      (s2),
        .val     (fin_val),
        .neg_val (fin_neg),
        .mag1    (mag1),
        .mag2    (mag2),
        .neg1    (neg1),
        .neg2    (neg2),
        .val_out (fin_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op     <= '0;
            opd    <= '0;
            hi     <= '0;
            lo     <= '0;
            neg1_r <= 1'b0;
            neg2_r <= 1'b0;
            byp    <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        state <= S_IDLE;
                        if (start) begin
                            state  <= S_CALC;
                            op     <= field;
                            cnt    <= '0;
                            hi     <= '0;
                            neg1_r <= neg1;
                            neg2_r <= neg2;
                            byp    <= div0 || ovf;
                            opd    <= is_div ? mag2 : mag1;
                            lo     <= (div0 || ovf) ? byp_val : (is_div ? mag1 : mag2);
                        end
                    end
                    S_CALC: begin
                        if (byp || cnt == CW'(XLEN)) begin
                            result <= byp ? lo : fin_res;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            cnt <= cnt + CW'(1);
                            if (op[2]) begin
                                hi <= div_ok ? div_d[XLEN-1:0] : div_t[XLEN-1:0];
                                lo <= {lo[XLEN-2:0], div_ok};
                            end else begin
                                hi <= mul_sum[XLEN:1];
                                lo <= {mul_sum[0], lo[XLEN-1:1]};
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at XLEN=32 and XLEN=8 against an
// arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, flush = 1'b0;
    logic [2:0]  field = '0;
    logic [31:0] op1 = '0, op2 = '0;
    logic        ready, done;
    logic [31:0] result;

    logic        start8 = 1'b0, flush8 = 1'b0;
    logic [2:0]  field8 = '0;
    logic [7:0]  op1_8 = '0, op2_8 = '0;
    logic        ready8, done8;
    logic [7:0]  result8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .field(field), .op1(op1), .op2(op2),
        .flush(flush), .ready(ready), .done(done), .result(result)
    );

    muldiv_unit #(.XLEN(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .field(field8), .op1(op1_8), .op2(op2_8),
        .flush(flush8), .ready(ready8), .done(done8), .result(result8)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    // Reference: plain integer arithmetic on w-bit values
    function automatic logic [31:0] model(input int w, input logic [2:0] f,
                                          input logic [31:0] a, input logic [31:0] b);
        longint mask = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ua = longint'(a) & mask;
        longint ub = longint'(b) & mask;
        longint sa = (ua ^ half) - half;
        longint sb = (ub ^ half) - half;
        longint r;
        logic [63:0] u;
        case (f)
            3'd0: r = ua * ub;
            3'd1: r = (sa * sb) >>> w;
            3'd2: r = (sa * ub) >>> w;
            3'd3: begin u = ua * ub; r = longint'(u >> w); end
            3'd4: r = (ub == 0) ? mask : (sa == -half && sb == -1) ? sa : sa / sb;
            3'd5: r = (ub == 0) ? mask : ua / ub;
            3'd6: r = (ub == 0) ? sa : (sa == -half && sb == -1) ? 0 : sa % sb;
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        return 32'(r & mask);
    endfunction

    function automatic int model_lat(input int w, input logic [2:0] f,
                                     input logic [31:0] a, input logic [31:0] b);
        longint mask = (longint'(1) << w) - 1;
        longint ua = longint'(a) & mask;
        longint ub = longint'(b) & mask;
        bit sdiv = (f == 3'd4) || (f == 3'd6);
        if (f[2] && (ub == 0 || (sdiv && ua == (longint'(1) << (w - 1)) && ub == mask)))
            return 1;
        return w + 1;
    endfunction

    function automatic logic [31:0] ropnd(input int w);
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'(longint'(1) << (w - 1));
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and wait (bounded) for its done pulse; lat=-1 on timeout
    task automatic do_op(input bit w8, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res,
                         output int lat, output bit one_pulse);
        if (w8) begin
            start8 = 1'b1; field8 = f; op1_8 = a[7:0]; op2_8 = b[7:0];
        end else begin
            start = 1'b1; field = f; op1 = a; op2 = b;
        end
        tick();
        start = 1'b0;
        start8 = 1'b0;
        lat = -1;
        res = 32'hDEAD_BEEF;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (w8 ? done8 : done) begin
                lat = k;
                res = w8 ? {24'h0, result8} : result;
                break;
            end
        end
        tick();
        one_pulse = !(w8 ? done8 : done);
    endtask

    task automatic test_reset();
        n_cmp++;
        if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++;
        if (result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", result); end
        n_cmp++;
        if (result8 !== 8'h0) begin n_err++; $display("FAIL reset_result8: got %h want 0", result8); end
    endtask

    task automatic test_directed();
        vec_t v[9] = '{
            '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33},
            '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33},
            '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33},
            '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33},
            '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33},
            '{3'b101, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1},
            '{3'b111, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1},
            '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
            '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1}
        };
        logic [31:0] res;
        int lat;
        bit one;
        for (int i = 0; i < 9; i++) begin
            do_op(1'b0, v[i].f, v[i].a, v[i].b, res, lat, one);
            n_cmp++;
            if (res !== v[i].exp) begin
                n_err++; $display("FAIL directed_result[%0d]: got %h want %h", i, res, v[i].exp);
            end
            n_cmp++;
            if (lat != v[i].lat) begin
                n_err++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, v[i].lat);
            end
            n_cmp++;
            if (!one) begin n_err++; $display("FAIL directed_pulse[%0d]: done still high, want 0", i); end
        end
    endtask

    task automatic test_random(input bit w8, input int n);
        int w = w8 ? 8 : 32;
        logic [31:0] a, b, res, exp;
        logic [2:0] f;
        int lat;
        bit one;
        for (int i = 0; i < n; i++) begin
            f = 3'($urandom_range(0, 7));
            a = ropnd(w);
            b = ropnd(w);
            exp = model(w, f, a, b);
            do_op(w8, f, a, b, res, lat, one);
            n_cmp++;
            if (res !== exp) begin
                n_err++;
                $display("FAIL random_result w%0d f%0d %h,%h: got %h want %h", w, f, a, b, res, exp);
            end
            n_cmp++;
            if (lat != model_lat(w, f, a, b)) begin
                n_err++;
                $display("FAIL random_latency w%0d f%0d: got %0d want %0d", w, f, lat, model_lat(w, f, a, b));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1 = $urandom, b1 = $urandom, a2 = $urandom, b2 = $urandom | 32'h1;
        int lat2 = -1;
        start = 1'b1; field = 3'b011; op1 = a1; op2 = b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done) break;
        end
        n_cmp++;
        if (result !== model(32, 3'b011, a1, b1)) begin
            n_err++; $display("FAIL b2b_first: got %h want %h", result, model(32, 3'b011, a1, b1));
        end
        n_cmp++;
        if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_in_done: got %b want 1", ready); end
        start = 1'b1; field = 3'b101; op1 = a2; op2 = b2;
        tick();
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || ready !== 1'b0) begin
            n_err++; $display("FAIL b2b_accept: done=%b ready=%b want 0/0", done, ready);
        end
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done) begin lat2 = k; break; end
        end
        n_cmp++;
        if (lat2 != 33) begin n_err++; $display("FAIL b2b_latency: got %0d want 33", lat2); end
        n_cmp++;
        if (result !== a2 / b2) begin n_err++; $display("FAIL b2b_second: got %h want %h", result, a2 / b2); end
        tick();
    endtask

    task automatic test_flush();
        logic [31:0] prev = result;
        int ndone = 0;
        int lat = -1;
        logic [31:0] res = 32'hDEAD_BEEF;
        start = 1'b1; field = 3'b000; op1 = 32'h1234; op2 = 32'h5678;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            n_err++; $display("FAIL flush_idle: ready=%b done=%b want 1/0", ready, done);
        end
        n_cmp++;
        if (result !== prev) begin n_err++; $display("FAIL flush_result_kept: got %h want %h", result, prev); end
        start = 1'b1; field = 3'b101; op1 = 32'd100; op2 = 32'd7;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done) begin ndone++; lat = k; res = result; end
        end
        n_cmp++;
        if (ndone != 1) begin n_err++; $display("FAIL flush_done_count: got %0d want 1", ndone); end
        n_cmp++;
        if (res !== 32'd14) begin n_err++; $display("FAIL flush_divu: got %h want %h", res, 32'd14); end
        n_cmp++;
        if (lat != 33) begin n_err++; $display("FAIL flush_divu_latency: got %0d want 33", lat); end
        // flush wins over a simultaneous start
        start = 1'b1; flush = 1'b1; field = 3'b000;
        tick();
        start = 1'b0; flush = 1'b0;
        n_cmp++;
        if (ready !== 1'b1) begin n_err++; $display("FAIL flush_priority: ready got %b want 1", ready); end
    endtask

    task automatic test_rst_mid();
        int ndone = 0;
        logic [31:0] res;
        int lat;
        bit one;
        start = 1'b1; field = 3'b001; op1 = $urandom; op2 = $urandom;
        start8 = 1'b1; field8 = 3'b011; op1_8 = 8'hA5; op2_8 = 8'h5A;
        tick();
        start = 1'b0; start8 = 1'b0;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (result !== 32'h0 || done !== 1'b0 || ready !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_async: result=%h done=%b ready=%b want 0/0/1", result, done, ready);
        end
        #1 rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done || done8) ndone++;
        end
        n_cmp++;
        if (ndone != 0) begin n_err++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", ndone); end
        do_op(1'b1, 3'b011, 32'hFF, 32'hFF, res, lat, one);
        n_cmp++;
        if (res !== 32'hFE) begin n_err++; $display("FAIL x8_mulhu: got %h want %h", res, 32'hFE); end
        n_cmp++;
        if (lat != 9) begin n_err++; $display("FAIL x8_latency: got %0d want 9", lat); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        test_reset();
        rst = 1'b0;
        test_directed();
        test_random(1'b0, 40);
        test_random(1'b1, 40);
        test_back_to_back();
        test_flush();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be even and >= 4.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled only while ready=1.
REQ-005 field  input  3  funct3 op select: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
REQ-006 op1  input  XLEN  rs1 value (multiplicand / dividend).
REQ-007 op2  input  XLEN  rs2 value (multiplier / divisor).
REQ-008 flush  input  1  abort in-flight operation (pipeline kill).
REQ-009 ready  output  1  high in IDLE and DONE; unit accepts start.
REQ-010 done  output  1  one-cycle pulse, result valid.
REQ-011 result  output  XLEN  registered result; held until next accepted start or reset.

Function
REQ-012 States SHALL be IDLE, CALC, DONE; start accepted when ready=1 and start=1 at edge N: field and operands latched, state->CALC (or DONE for special cases).
REQ-013 CALC SHALL perform exactly XLEN radix-2 iterations (shift-add multiply, restoring divide), one per edge, on unsigned magnitudes; iteration counter width clog2(XLEN)+1.
REQ-014 After the last iteration, one further edge SHALL apply sign correction, register result and enter DONE; done=1 for the cycle after edge N+XLEN+1.
REQ-015 DONE SHALL last one cycle, done deasserts, state->IDLE unless a new start is accepted in that cycle (back-to-back allowed, ready=1 in DONE).
REQ-016 Signedness: MUL/MULH/DIV/REM both signed; MULHSU op1 signed, op2 unsigned; MULHU/DIVU/REMU unsigned.
REQ-017 MUL returns low XLEN of 2*XLEN product; MULH/MULHSU/MULHU return high XLEN.
REQ-018 DIV/DIVU quotient truncates toward zero; REM/REMU remainder takes dividend sign.
REQ-019 Divide by zero: quotient all-ones, remainder = op1; SHALL bypass CALC, done for the cycle after edge N+1.
REQ-020 Signed overflow (DIV/REM with op1 = most-negative, op2 = all-ones): quotient = op1, remainder = 0; same 2-cycle bypass.
REQ-021 start while ready=0 SHALL be ignored; no queuing.
REQ-022 flush=1 at any edge SHALL force IDLE, done=0, result unchanged; flush has priority over a simultaneous start.
REQ-023 Invalid field impossible (3-bit fully decoded); no exception output.

Reset
REQ-024 rst=1 SHALL asynchronously force state IDLE, counter 0, done 0, result 0, ready 1, internal operand/accumulator registers 0.
REQ-025 rst asserted mid-CALC SHALL discard the operation; no done pulse after release.
REQ-026 First start SHALL be accepted at the first rising edge after rst deasserts.

Structure
REQ-027 Shared package muldiv_pkg SHALL hold field encodings (localparams), state enum typedef and XLEN default.
REQ-028 One sub-module, muldiv_sign (combinational: operand magnitude/sign extraction and final negation), SHALL be instantiated; datapath and FSM stay in muldiv_unit.

Verification
REQ-029 MULH 0x80000000 x 0x80000000 (XLEN=32) -> result 0x40000000, done exactly 33 cycles after start edge.
REQ-030 MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MUL same operands -> 0x00000001.
REQ-031 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF, REMU 7/0 -> 7 with done 1 cycle after start edge.
REQ-032 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0, 2-cycle bypass.
REQ-033 Start MUL, flush at iteration 10, start DIVU 100/7 next cycle -> no done for MUL, result 14 with single done pulse.
REQ-034 rst pulsed mid-CALC -> result 0, no done; repeat with XLEN=8: MULHU 0xFF x 0xFF -> 0xFE, done 9 cycles after start edge.
